// File: rtl/btn_press_fsm_pkg.sv
// rtl/btn_press_fsm_pkg.sv - shared FSM state codes and board timing constants
package btn_press_fsm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_DB_PRESS   = 3'd1;
    localparam state_t ST_HELD       = 3'd2;
    localparam state_t ST_LONG       = 3'd3;
    localparam state_t ST_DB_RELEASE = 3'd4;

    localparam int unsigned BOARD_CLK_HZ        = 100_000_000;
    // 10 ms debounce window and 1 s long-press threshold at the board clock
    localparam int unsigned DEF_DEBOUNCE_CYCLES = BOARD_CLK_HZ / 100;
    localparam int unsigned DEF_LONG_CYCLES     = BOARD_CLK_HZ;

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchronizer for asynchronous button/switch inputs
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_press_fsm.sv
// rtl/btn_press_fsm.sv - debounced pushbutton with short/long press classification
module btn_press_fsm
    import btn_press_fsm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN0,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic [7:0] press_count,
    output logic [1:0] step
);

    localparam logic [31:0] DB_LAST   = DEBOUNCE_CYCLES - 1;
    localparam logic [31:0] HOLD_LAST = LONG_CYCLES - 1;

    logic        btn_sync;
    state_t      state;
    logic [31:0] cnt;
    logic [31:0] hcnt;
    logic        lf;

    btn_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (BTN0),
        .q   (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            hcnt          <= '0;
            lf            <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= '0;
            step          <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;

            // counters follow the registered pulses, so they lag them by a cycle
            if (press_pulse)
                press_count <= press_count + 8'd1;
            if (short_press)
                step <= step + 2'd1;
            else if (long_press)
                step <= 2'd0;

            case (state)
                ST_IDLE: begin
                    if (btn_sync) begin
                        state <= ST_DB_PRESS;
                        cnt   <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (!btn_sync) begin
                        state <= ST_IDLE;
                    end else if (cnt == DB_LAST) begin
                        state       <= ST_HELD;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        hcnt        <= '0;
                        lf          <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_HELD: begin
                    if (!btn_sync) begin
                        state <= ST_DB_RELEASE;
                        cnt   <= '0;
                    end else if (hcnt == HOLD_LAST) begin
                        state      <= ST_LONG;
                        long_press <= 1'b1;
                        lf         <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 32'd1;
                    end
                end
                ST_LONG: begin
                    if (!btn_sync) begin
                        state <= ST_DB_RELEASE;
                        cnt   <= '0;
                    end
                end
                ST_DB_RELEASE: begin
                    // a short low glitch returns to the hold state without touching hcnt
                    if (btn_sync) begin
                        state <= lf ? ST_LONG : ST_HELD;
                    end else if (cnt == DB_LAST) begin
                        state         <= ST_IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                        short_press   <= !lf;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_fsm.sv
// tb/tb_btn_press_fsm.sv - scoreboard bench for btn_press_fsm
module tb_btn_press_fsm;

    localparam int EV_PRESS = 0;
    localparam int EV_REL   = 1;
    localparam int EV_SHORT = 2;
    localparam int EV_LONG  = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    bit         clk;
    logic       rst;
    logic       BTN0;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic [7:0] press_count;
    logic [1:0] step;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  exp_count = 0;
    int  exp_step = 0;
    ev_t sb[$];

    btn_press_fsm #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .BTN0          (BTN0),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .press_count   (press_count),
        .step          (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [3:0] ev;
        ev_t e;
        ev = {long_press, short_press, release_pulse, press_pulse};
        for (int i = 0; i < 4; i++) begin
            if (ev[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("ev_unexpected", i, 99);
                end else begin
                    e = sb.pop_front();
                    chk("ev_kind", i, e.kind);
                    chk("ev_cyc", cyc, e.cyc);
                end
            end
        end
    end

    // Short press: 10 cycles high, 10 low; press and release each land 7 edges after the drive.
    task automatic do_short();
        int n;
        n = cyc;
        BTN0 = 1'b1;
        push(EV_PRESS, n + 7);
        exp_count++;
        tick(10);
        n = cyc;
        BTN0 = 1'b0;
        push(EV_REL, n + 7);
        push(EV_SHORT, n + 7);
        exp_step = (exp_step + 1) % 4;
        tick(10);
    endtask

    function automatic int outs_word();
        return int'({btn_level, press_pulse, release_pulse, short_press, long_press,
                     press_count, step});
    endfunction

    initial begin
        int n;
        int m;
        rst  = 1'b1;
        BTN0 = 1'b0;
        tick(3);
        chk("reset_outs", outs_word(), 0);
        rst = 1'b0;
        tick(2);

        // clean press
        n = cyc;
        BTN0 = 1'b1;
        push(EV_PRESS, n + 7);
        exp_count++;
        tick(10);
        chk("clean_level_hi", btn_level, 1);
        m = cyc;
        BTN0 = 1'b0;
        push(EV_REL, m + 7);
        push(EV_SHORT, m + 7);
        exp_step = 1;
        tick(10);
        chk("clean_count", press_count, 1);
        chk("clean_step", step, 1);
        chk("clean_level_lo", btn_level, 0);

        // bounce
        repeat (5) begin
            BTN0 = 1'b1;
            tick(2);
            BTN0 = 1'b0;
            tick(1);
            chk("bounce_level", btn_level, 0);
        end
        tick(10);
        chk("bounce_count", press_count, exp_count);

        // long press
        n = cyc;
        BTN0 = 1'b1;
        push(EV_PRESS, n + 7);
        push(EV_LONG, n + 7 + 16);
        exp_count++;
        exp_step = 0;
        tick(40);
        chk("long_step", step, 0);
        m = cyc;
        BTN0 = 1'b0;
        push(EV_REL, m + 7);
        tick(10);
        chk("long_count", press_count, exp_count);

        // release glitch: 3 edges spent away from HELD are not counted toward the hold
        n = cyc;
        BTN0 = 1'b1;
        push(EV_PRESS, n + 7);
        push(EV_LONG, n + 7 + 16 + 3);
        exp_count++;
        tick(10);
        BTN0 = 1'b0;
        tick(2);
        BTN0 = 1'b1;
        tick(4);
        chk("glitch_level", btn_level, 1);
        tick(26);
        m = cyc;
        BTN0 = 1'b0;
        push(EV_REL, m + 7);
        tick(10);
        chk("glitch_step", step, 0);

        // step wrap
        for (int i = 0; i < 5; i++) begin
            do_short();
            chk("wrap_step", step, exp_step);
        end
        chk("wrap_count", press_count, exp_count);

        // reset while held
        n = cyc;
        BTN0 = 1'b1;
        push(EV_PRESS, n + 7);
        tick(10);
        rst = 1'b1;
        m = cyc;
        tick(1);
        chk("midrst_outs", outs_word(), 0);
        rst = 1'b0;
        push(EV_PRESS, m + 8);
        exp_count = 1;
        exp_step = 0;
        tick(12);
        chk("midrst_count", press_count, 1);
        m = cyc;
        BTN0 = 1'b0;
        push(EV_REL, m + 7);
        push(EV_SHORT, m + 7);
        exp_step = 1;
        tick(10);
        chk("midrst_step", step, exp_step);

        // press_count wrap after 256 presses
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_count = 0;
        exp_step = 0;
        tick(2);
        repeat (256) do_short();
        chk("count_wrap", press_count, exp_count % 256);
        chk("count_wrap_step", step, exp_step);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_press_fsm.md
# btn_press_fsm

Pushbutton input conditioner and press classifier for the board's user-button path, the input-side counterpart of the LED pattern sequencers. Synchronizes a raw asynchronous button, debounces it with a counter-based state machine, and classifies each debounced press as short or long. Emits single-cycle event pulses, a press counter, and a 2-bit step index that LED sequencers consume as their advance/clear source.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: cycles the synchronized input must stay stable before a level change is accepted (10 ms at 100 MHz); legal range 1 to 2^32-1.
- LONG_CYCLES, default 100_000_000: cycles of debounced hold after which a press is long (1 s at 100 MHz); legal range 1 to 2^32-1.
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- BTN0  input  1  raw asynchronous pushbutton, 1 = pressed.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle pulse on each debounced press.
- release_pulse  output  1  one-cycle pulse on each debounced release.
- short_press  output  1  one-cycle pulse on release of a press held less than LONG_CYCLES.
- long_press  output  1  one-cycle pulse when a held press reaches LONG_CYCLES; fires while still held.
- press_count  output  8  count of debounced presses.
- step  output  2  step index: +1 per short_press, cleared by long_press.

## Operation
- Synchronizer: two flops on BTN0; output btn_sync; both reset to 0.
- Counters: 32-bit debounce counter cnt; 32-bit hold counter hcnt; long flag lf.
- States: IDLE, DB_PRESS, HELD, LONG, DB_RELEASE.
- IDLE: btn_sync=1 -> DB_PRESS, cnt<=0.
- DB_PRESS: btn_sync=0 -> IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> HELD with btn_level<=1, press_pulse, hcnt<=0, lf<=0; else cnt++.
- HELD: btn_sync=0 -> DB_RELEASE, cnt<=0. Otherwise, if hcnt==LONG_CYCLES-1 -> LONG with long_press, lf<=1; else hcnt++.
- LONG: btn_sync=0 -> DB_RELEASE, cnt<=0. hcnt is frozen.
- DB_RELEASE: btn_sync=1 (glitch) -> back to LONG if lf, else HELD. hcnt resumes from its held value.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE with btn_level<=0 and release_pulse, plus short_press if lf==0; else cnt++.
- press_count increments on press_pulse; wraps 255->0.
- step increments modulo 4 on short_press (3->0) and clears to 0 on long_press. These pulses are mutually exclusive by construction.
- Event outputs are registered. Each is high for exactly one cycle and 0 otherwise.

## Timing
- Reset: every output is 0; the state is IDLE; cnt, hcnt, lf and the synchronizer flops are all 0.
- Reset asserted mid-press aborts with no pulses. After reset, a button still held is re-qualified through DB_PRESS from scratch.
- Press latency: if BTN0 is first sampled high at edge k and stays high, press_pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+2.
- Release latency, measured from the first edge sampling BTN0 low, is the same: DEBOUNCE_CYCLES+2 edges.
- long_press fires LONG_CYCLES cycles after press_pulse if the button is held continuously. Glitch time spent in DB_RELEASE is not counted.
- Any bounce shorter than DEBOUNCE_CYCLES resets qualification and produces no pulse.
- press_count and step update one cycle after the pulse that drives them.

## Structure
- Shared package: the state enum (IDLE..DB_RELEASE, 3-bit) and the default DEBOUNCE_CYCLES / LONG_CYCLES constants. Board-clock-derived timing constants live there as well.
- Sub-module: btn_sync, the 2-flop synchronizer. It is reused for the switch inputs. The FSM, counters and outputs stay in btn_press_fsm.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=16.
- Clean press: BTN0 held high from edge k for 10 cycles, then low for 10 cycles.
  - press_pulse in the cycle after edge k+6; release_pulse and short_press 6 edges after the fall.
  - press_count=1, step=1.
- Bounce: BTN0 toggles high 2 cycles / low 1 cycle, 5 times, then stays low. No pulses; btn_level stays 0; press_count=0.
- Long press: BTN0 held high for 40 cycles, then released.
  - long_press exactly 16 cycles after press_pulse; step=0.
  - release_pulse on release with no short_press.
- Release glitch: during HELD, BTN0 low for 2 cycles, then high.
  - No release_pulse; btn_level stays 1.
  - long_press still occurs at 16 hold cycles, excluding the glitch cycles.
- Wrap: 5 short presses give step sequence 1,2,3,0,1. After 256 presses press_count reads 0.
- Reset mid-operation: rst asserted for 1 cycle while in HELD.
  - All outputs are 0 the next cycle.
  - With BTN0 still high, a new press_pulse occurs 6 edges later.
